pipeline_step_ctrl: RTL and testbench

Debug-side run/step controller that drives the shared `i_step` enable and `i_flush_latch` clear of every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB). It decodes single-byte commands from the debug UART receiver and runs the pipeline either continuously or one cycle per command. It stops on the `halt` flag arriving at write-back and hands a report request to the debug transmitter after each step or halt. It is the source end of the step/flush interface that all pipeline latches consume.

---
 rtl/mips_dbg_pkg.sv | 22 ++
 rtl/dbg_cycle_counter.sv | 28 ++
 rtl/pipeline_step_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipeline_step_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the debug run/step controller.
// Holds the controller state encoding, the debug UART command bytes and
// the default length of a pipeline flush.
package mips_dbg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StStep,
    StReport,
    StHalted,
    StFlush
  } dbg_state_e;

  localparam logic [7:0] CMD_RUN   = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_PAUSE = 8'h50;  // 'P'
  localparam logic [7:0] CMD_RESET = 8'h52;  // 'R'

  localparam int unsigned DEFAULT_FLUSH_CYCLES = 5;

endpackage

// File: rtl/dbg_cycle_counter.sv
// Saturating up-counter shared by the step controller and the register dump.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-high reset, clears the count
//   clear  - synchronous clear, wins over enable
//   enable - count one when high
//   count  - current value, sticks at all-ones
module dbg_cycle_counter #(
  parameter int unsigned BITS_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  output logic [BITS_SIZE-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_step_ctrl.sv
// Debug run/step controller: drives the shared step enable and flush clear of
// every pipeline latch from single-byte debug UART commands, stops on the
// write-back halt flag and requests a report after each step or halt.
// Optional feature: define PIPELINE_STEP_CTRL_CYCLE_LIMIT_EN to stop a run
// once the cycle counter reaches MAX_CYCLES (sets o_timeout).
// Ports:
//   i_clk, i_reset  - clock, asynchronous active-high reset
//   i_cmd_valid     - one-cycle strobe qualifying i_cmd
//   i_cmd           - command byte (C run, S step, P pause, R pipeline reset)
//   i_halt          - halt bit at the MEM/WB latch output
//   i_report_ready  - debug transmitter accepts the report
//   o_step          - registered latch enable
//   o_flush_latch   - registered latch clear
//   o_report_valid  - report request, held until accepted
//   o_cycle_count   - step cycles since the last pipeline reset
//   o_halted        - controller halted
//   o_running       - controller free-running
//   o_timeout       - sticky run-limit flag
module pipeline_step_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int unsigned BITS_SIZE    = 32,
  parameter int unsigned FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
  parameter int unsigned MAX_CYCLES   = 32'd1_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [7:0]           i_cmd,
  input  logic                 i_halt,
  input  logic                 i_report_ready,
  output logic                 o_step,
  output logic                 o_flush_latch,
  output logic                 o_report_valid,
  output logic [BITS_SIZE-1:0] o_cycle_count,
  output logic                 o_halted,
  output logic                 o_running,
  output logic                 o_timeout
);

  localparam int unsigned FlushW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FlushW-1:0] FlushLast = FlushW'(FLUSH_CYCLES - 1);

  dbg_state_e        state_q, state_d;
  logic              halt_seen_q, halt_seen_d;
  logic              timeout_q, timeout_d;
  logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
  logic              step_q, flush_q, report_q, halted_q, running_q;
  logic              limit_hit;
  logic              count_clear;
  logic [BITS_SIZE-1:0] count;

  logic cmd_run, cmd_step, cmd_pause, cmd_reset;
  assign cmd_run   = i_cmd_valid && (i_cmd == CMD_RUN);
  assign cmd_step  = i_cmd_valid && (i_cmd == CMD_STEP);
  assign cmd_pause = i_cmd_valid && (i_cmd == CMD_PAUSE);
  assign cmd_reset = i_cmd_valid && (i_cmd == CMD_RESET);

`ifdef PIPELINE_STEP_CTRL_CYCLE_LIMIT_EN
  // Count value after this edge; stopping on it yields exactly MAX_CYCLES steps.
  logic [BITS_SIZE:0] count_next;
  assign count_next = {1'b0, count} + {{BITS_SIZE{1'b0}}, step_q};
  assign limit_hit  = count_next >= (BITS_SIZE + 1)'(MAX_CYCLES);
`else
  logic unused_max_cycles;
  assign unused_max_cycles = ^MAX_CYCLES;
  assign limit_hit         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    halt_seen_d = halt_seen_q | (i_halt && (state_q != StFlush));
    timeout_d   = timeout_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_run) begin
          state_d = halt_seen_q ? StHalted : StRun;
        end else if (cmd_step) begin
          state_d = halt_seen_q ? StHalted : StStep;
        end else if (cmd_reset) begin
          state_d = StFlush;
        end
      end
      StRun: begin
        // Halt outranks every command arriving in the same cycle.
        if (i_halt) begin
          state_d = StReport;
        end else if (limit_hit) begin
          state_d   = StReport;
          timeout_d = 1'b1;
        end else if (cmd_reset) begin
          state_d = StFlush;
        end else if (cmd_pause) begin
          state_d = StIdle;
        end
      end
      StStep: begin
        state_d = StReport;
      end
      StReport: begin
        if (i_report_ready) begin
          state_d = (halt_seen_q || timeout_q) ? StHalted : StIdle;
        end
      end
      StHalted: begin
        if (cmd_reset) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (flush_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if ((state_d == StFlush) && (state_q != StFlush)) begin
      flush_cnt_d = FlushLast;
      halt_seen_d = 1'b0;
      timeout_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= StIdle;
      halt_seen_q <= 1'b0;
      timeout_q   <= 1'b0;
      flush_cnt_q <= '0;
      step_q      <= 1'b0;
      flush_q     <= 1'b0;
      report_q    <= 1'b0;
      halted_q    <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_seen_q <= halt_seen_d;
      timeout_q   <= timeout_d;
      flush_cnt_q <= flush_cnt_d;
      // Outputs are decoded from the next state so they are glitch-free flops.
      step_q      <= (state_d == StRun) || (state_d == StStep);
      flush_q     <= (state_d == StFlush);
      report_q    <= (state_d == StReport);
      halted_q    <= (state_d == StHalted);
      running_q   <= (state_d == StRun);
    end
  end

  assign count_clear = (state_d == StFlush);

  dbg_cycle_counter #(
    .BITS_SIZE(BITS_SIZE)
  ) u_cycle_counter (
    .clk   (i_clk),
    .rst   (i_reset),
    .clear (count_clear),
    .enable(step_q),
    .count (count)
  );

  assign o_step         = step_q;
  assign o_flush_latch  = flush_q;
  assign o_report_valid = report_q;
  assign o_cycle_count  = count;
  assign o_halted       = halted_q;
  assign o_running      = running_q;
  assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Self-checking bench for pipeline_step_ctrl: directed scenarios followed by
// random operation sequences, checked against an operation-level model that
// tracks the expected cycle count and halted status.
module tb_pipeline_step_ctrl;
  import mips_dbg_pkg::*;

  localparam int unsigned TbMax = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic        halt = 1'b0;
  logic        ready = 1'b0;
  logic        step, flush, rv, halted, running, timeout;
  logic [31:0] count;

  pipeline_step_ctrl #(
    .BITS_SIZE   (32),
    .FLUSH_CYCLES(5),
    .MAX_CYCLES  (TbMax)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_cmd_valid   (cmd_valid),
    .i_cmd         (cmd),
    .i_halt        (halt),
    .i_report_ready(ready),
    .o_step        (step),
    .o_flush_latch (flush),
    .o_report_valid(rv),
    .o_cycle_count (count),
    .o_halted      (halted),
    .o_running     (running),
    .o_timeout     (timeout)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          step_seen = 0;
  int          flush_seen = 0;
  int unsigned exp_count = 0;
  logic        exp_halted = 1'b0;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (step === 1'b1) step_seen++;
    if (flush === 1'b1) flush_seen++;
    if (step === 1'b1 || flush === 1'b1) check("step_flush_exclusive", step & flush, 0);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd = b;
    tick();
    cmd_valid = 1'b0;
    cmd = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_step"}, step, 0);
    check({tag, "_flush"}, flush, 0);
    check({tag, "_report"}, rv, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_running"}, running, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic do_report(input int delay);
    int w;
    w = 0;
    while (rv !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check("report_valid_rise", rv, 1);
    for (int d = 0; d < delay; d++) begin
      if (d == 0) begin
        cmd_valid = 1'b1;
        cmd = CMD_RUN;
      end
      tick();
      cmd_valid = 1'b0;
      check("report_hold", rv, 1);
      check("report_count_stable", count, exp_count);
      check("report_no_step", step, 0);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("report_drop", rv, 0);
    check("report_cmd_dropped", running, 0);
  endtask

  task automatic op_step();
    send_cmd(CMD_STEP);
    if (exp_halted) begin
      check("halted_step_ignored", step, 0);
      check("halted_hold_s", halted, 1);
    end else begin
      check("step_pulse", step, 1);
      tick();
      exp_count++;
      check("step_single", step, 0);
      check("step_report", rv, 1);
      check("step_count", count, exp_count);
      do_report(int'($urandom_range(0, 3)));
      check("step_back_idle", halted, 0);
    end
  endtask

  // mode 0: halt, 1: pause, 2: halt and pause together.
  task automatic op_run(input int n, input int mode);
    send_cmd(CMD_RUN);
    if (exp_halted) begin
      check("halted_run_ignored", step, 0);
      check("halted_not_running", running, 0);
      check("halted_hold_c", halted, 1);
    end else begin
      check("run_running", running, 1);
      check("run_step_first", step, 1);
      for (int k = 1; k < n; k++) begin
        if (k == 1) begin
          cmd_valid = 1'b1;
          cmd = 8'h41;
        end
        tick();
        cmd_valid = 1'b0;
      end
      check("run_count_mid", count, exp_count + n - 1);
      check("run_still_step", step, 1);
      check("run_unknown_ignored", running, 1);
      if (mode != 1) halt = 1'b1;
      if (mode != 0) begin
        cmd_valid = 1'b1;
        cmd = CMD_PAUSE;
      end
      tick();
      halt = 1'b0;
      cmd_valid = 1'b0;
      exp_count += n;
      check("run_stop", step, 0);
      check("run_count_final", count, exp_count);
      check("run_not_running", running, 0);
      if (mode == 1) begin
        check("pause_no_report", rv, 0);
        check("pause_not_halted", halted, 0);
      end else begin
        check("halt_report", rv, 1);
        do_report(int'($urandom_range(0, 3)));
        exp_halted = 1'b1;
        check("halt_halted", halted, 1);
      end
    end
  endtask

  task automatic op_flush();
    int f0;
    f0 = flush_seen;
    send_cmd(CMD_RESET);
    for (int k = 0; k < 5; k++) begin
      check("flush_high", flush, 1);
      check("flush_no_step", step, 0);
      check("flush_count_clr", count, 0);
      if (k == 2) send_cmd(CMD_STEP);
      else tick();
    end
    check("flush_done", flush, 0);
    check("flush_len", flush_seen - f0, 5);
    check("flush_idle_step", step, 0);
    check("flush_not_halted", halted, 0);
    check("flush_not_running", running, 0);
    check("flush_timeout_clr", timeout, 0);
    exp_count = 0;
    exp_halted = 1'b0;
    step_seen = 0;
  endtask

  task automatic op_unknown();
    send_cmd(8'h41);
    check("unk_no_step", step, 0);
    check("unk_not_running", running, 0);
    check("unk_halted", halted, exp_halted);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_count"}, count, exp_count);
    check({tag, "_halted"}, halted, exp_halted);
    check({tag, "_pulses"}, step_seen, exp_count);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    check_all_zero("post_reset");

    repeat (3) op_step();
    check("three_steps_count", count, 3);
    check("three_steps_pulses", step_seen, 3);
    check("three_steps_idle", halted, 0);

`ifndef PIPELINE_STEP_CTRL_CYCLE_LIMIT_EN
    op_flush();
    op_run(20, 0);
    check("halt20_count", count, 20);
    op_run(5, 0);
    op_step();
    op_unknown();
    check_model("halted_cmds");
    op_flush();
    op_run(7, 2);
    check("halt_beats_pause", halted, 1);
    op_flush();
    op_unknown();
    op_run(3, 1);
    check_model("pause");

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: op_step();
        1: op_run(int'($urandom_range(1, 30)), 0);
        2: op_run(int'($urandom_range(1, 30)), 1);
        3: op_run(int'($urandom_range(1, 30)), 2);
        4: op_flush();
        default: op_unknown();
      endcase
      check_model("random");
    end

    // Reset in the middle of a run.
    op_flush();
    send_cmd(CMD_RUN);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1 check_all_zero("reset_mid_run");
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    exp_halted = 1'b0;
    step_seen = 0;
`endif

    // Reset in cycle 2 of a flush.
    send_cmd(CMD_RESET);
    tick();
    check("flush_cycle2", flush, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("reset_mid_flush");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    check("no_flush_after_reset", flush, 0);
    check("no_step_after_reset", step, 0);
    exp_count = 0;
    exp_halted = 1'b0;
    step_seen = 0;
    op_step();
    check_model("after_reset");

    op_flush();
`ifdef PIPELINE_STEP_CTRL_CYCLE_LIMIT_EN
    send_cmd(CMD_RUN);
    for (int w = 0; w < 40 && step === 1'b1; w++) tick();
    exp_count = TbMax;
    check("limit_pulses", step_seen, TbMax);
    check("limit_step_low", step, 0);
    check("limit_timeout", timeout, 1);
    check("limit_report", rv, 1);
    do_report(1);
    exp_halted = 1'b1;
    check("limit_halted", halted, 1);
    check("limit_count", count, TbMax);
`else
    send_cmd(CMD_RUN);
    repeat (14) tick();
    check("nolimit_step", step, 1);
    check("nolimit_running", running, 1);
    check("nolimit_timeout", timeout, 0);
    check("nolimit_count", count, 14);
    send_cmd(CMD_PAUSE);
    exp_count = 15;
    check_model("nolimit");
    check("nolimit_timeout_end", timeout, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
